// File: rtl/snake_link_pkg.sv
// Shared definitions for the inter-board player link (rx and tx ends).
// SNAKE_LINK_PARITY_EN adds an even-parity bit (8E1) and the PARITY rx state.
package snake_link_pkg;

  localparam int LINK_DATA_W = 8;
  localparam int LINK_CLK_HZ = 75000000;
  localparam int LINK_BAUD   = 115200;

  function automatic int link_clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

`ifdef SNAKE_LINK_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_WAIT_HIGH
  } rx_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_WAIT_HIGH
  } rx_state_e;
`endif

endpackage

// File: rtl/snake_sync.sv
// Flop-chain synchroniser for asynchronous inputs; resets to 1 (idle-high lines).
module snake_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '1;
    else        r_sync <= {r_sync[STAGES-2:0], i_d};
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/snake_link_rx.sv
// 8N1 link receiver with mid-bit sampling and a one-entry valid/ready holding register.
// Define SNAKE_LINK_PARITY_EN for 8E1 framing with a parity_err pulse.
module snake_link_rx
  import snake_link_pkg::*;
#(
  parameter int CLK_HZ       = LINK_CLK_HZ,
  parameter int BAUD         = LINK_BAUD,
  parameter int CLKS_PER_BIT = link_clks_per_bit(CLK_HZ, BAUD),
  parameter int SYNC_STAGES  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rx,
  output logic [LINK_DATA_W-1:0] data,
  output logic                   valid,
  input  logic                   ready,
  output logic                   frame_err,
  output logic                   overrun,
  output logic                   busy
`ifdef SNAKE_LINK_PARITY_EN
  , output logic                 parity_err
`endif
);

  localparam int TW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [TW-1:0] TICK_FULL = TW'(CLKS_PER_BIT);
  localparam logic [TW-1:0] TICK_HALF = TW'(CLKS_PER_BIT / 2);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);

  rx_state_e               r_state, w_state_nxt;
  logic [TW-1:0]           r_tick, w_tick_nxt;
  logic [2:0]              r_bit, w_bit_nxt;
  logic [LINK_DATA_W-1:0]  r_shift, w_shift_nxt;
  logic [LINK_DATA_W-1:0]  r_data;
  logic                    r_valid, r_ferr, r_ovr, r_rx_d, r_armed;
  logic [SYNC_STAGES-1:0]  r_flush;
  logic                    w_rx_s, w_fall, w_tick_hit, w_load, w_ferr, w_ovr, w_good;

  snake_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (rx),
    .o_q   (w_rx_s)
  );

  // Edges are ignored until the chain has flushed its reset value and rx_s is seen high,
  // so a line held low through reset exit does not start a frame.
  assign w_fall     = r_armed & r_rx_d & ~w_rx_s;
  assign w_tick_hit = (r_tick == TICK_ONE);

`ifdef SNAKE_LINK_PARITY_EN
  logic r_par, w_par_nxt, r_perr, w_perr;
  assign w_good = ~^{r_shift, r_par};
`else
  assign w_good = 1'b1;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = (r_tick != '0) ? r_tick - TICK_ONE : '0;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_load      = 1'b0;
    w_ferr      = 1'b0;
    w_ovr       = 1'b0;
`ifdef SNAKE_LINK_PARITY_EN
    w_par_nxt   = r_par;
    w_perr      = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        w_tick_nxt = '0;
        if (w_fall) begin
          w_state_nxt = ST_START;
          w_tick_nxt  = TICK_HALF;
        end
      end
      ST_START: if (w_tick_hit) begin
        w_bit_nxt = 3'd0;
        if (!w_rx_s) begin
          w_state_nxt = ST_DATA;
          w_tick_nxt  = TICK_FULL;
        end else begin
          w_state_nxt = ST_IDLE;
          w_tick_nxt  = '0;
        end
      end
      ST_DATA: if (w_tick_hit) begin
        w_shift_nxt = {w_rx_s, r_shift[LINK_DATA_W-1:1]};
        w_tick_nxt  = TICK_FULL;
        if (r_bit == 3'd7) begin
          w_bit_nxt = 3'd0;
`ifdef SNAKE_LINK_PARITY_EN
          w_state_nxt = ST_PARITY;
`else
          w_state_nxt = ST_STOP;
`endif
        end else begin
          w_bit_nxt = r_bit + 3'd1;
        end
      end
`ifdef SNAKE_LINK_PARITY_EN
      ST_PARITY: if (w_tick_hit) begin
        w_par_nxt   = w_rx_s;
        w_tick_nxt  = TICK_FULL;
        w_state_nxt = ST_STOP;
      end
`endif
      ST_STOP: if (w_tick_hit) begin
        w_tick_nxt = '0;
        if (w_rx_s) begin
          w_state_nxt = ST_IDLE;
`ifdef SNAKE_LINK_PARITY_EN
          w_perr = ~w_good;
`endif
          w_ovr  = w_good & r_valid & ~ready;
          w_load = w_good & (~r_valid | ready);
        end else begin
          w_state_nxt = ST_WAIT_HIGH;
          w_ferr      = 1'b1;
        end
      end
      ST_WAIT_HIGH: if (w_rx_s) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tick  <= w_tick_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_d  <= 1'b1;
      r_flush <= '0;
      r_armed <= 1'b0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_rx_d  <= w_rx_s;
      r_flush <= {r_flush[SYNC_STAGES-2:0], 1'b1};
      r_armed <= r_armed | (r_flush[SYNC_STAGES-1] & w_rx_s);
      if (w_load) r_data <= r_shift;
      if (w_load)                r_valid <= 1'b1;
      else if (r_valid && ready) r_valid <= 1'b0;
      r_ferr  <= w_ferr;
      r_ovr   <= w_ovr;
    end
  end

`ifdef SNAKE_LINK_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par  <= 1'b0;
      r_perr <= 1'b0;
    end else begin
      r_par  <= w_par_nxt;
      r_perr <= w_perr;
    end
  end
  assign parity_err = r_perr;
`endif

  assign data      = r_data;
  assign valid     = r_valid;
  assign frame_err = r_ferr;
  assign overrun   = r_ovr;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_snake_link_rx.sv
// Directed bench for snake_link_rx at 16 clocks per bit; honours SNAKE_LINK_PARITY_EN.
module tb_snake_link_rx;

  localparam int CPB  = 16;
  localparam int SYNC = 2;
`ifdef SNAKE_LINK_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // start edge -> stop mid-sample, plus synchroniser, plus the registered valid
  localparam int LATENCY = (NBITS - 1) * CPB + CPB / 2 + SYNC + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       ready = 1'b1;
  logic [7:0] data;
  logic       valid, frame_err, overrun, busy;
`ifdef SNAKE_LINK_PARITY_EN
  logic       parity_err;
`endif

  snake_link_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
`ifdef SNAKE_LINK_PARITY_EN
    , .parity_err (parity_err)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  int cyc = 0;
  int n_vrise = 0, n_vhigh = 0, n_ferr = 0, n_ovr = 0, n_perr = 0;
  int t_valid = 0, t_start = 0;
  logic [7:0] cap_data = 8'h00;
  logic prev_v = 1'b0;
  int v0, h0, f0, o0, p0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid && !prev_v) begin
      n_vrise++;
      cap_data = data;
      t_valid  = cyc;
    end
    if (valid) n_vhigh++;
    prev_v = valid;
    if (frame_err) n_ferr++;
    if (overrun) n_ovr++;
`ifdef SNAKE_LINK_PARITY_EN
    if (parity_err) n_perr++;
`endif
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    v0 = n_vrise; h0 = n_vhigh; f0 = n_ferr; o0 = n_ovr; p0 = n_perr;
  endtask

  task automatic tx_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input logic stop_b);
    tx_bit(1'b0);
    for (int i = 0; i < 8; i++) tx_bit(d[i]);
`ifdef SNAKE_LINK_PARITY_EN
    tx_bit(^d);
`endif
    tx_bit(stop_b);
    rx = 1'b1;
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check("rst_data", data, 8'h00);
    check("rst_valid", valid, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_ovr", overrun, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);

    // 0xA5, ready=1: single-cycle valid at the expected latency
    snap();
    t_start = cyc;
    send(8'hA5, 1'b1);
    repeat (4) @(negedge clk);
    check("a5_vrise", n_vrise - v0, 1);
    check("a5_data", cap_data, 8'hA5);
    check("a5_latency", t_valid - t_start, LATENCY);
    check("a5_vwidth", n_vhigh - h0, 1);
    check("a5_ferr", n_ferr - f0, 0);
    check("a5_valid_low", valid, 1'b0);

    // ready=0: 0x3C held, 0x7E overruns, then drain
    ready = 1'b0;
    snap();
    send(8'h3C, 1'b1);
    check("hold_data1", data, 8'h3C);
    send(8'h7E, 1'b1);
    repeat (2) @(negedge clk);
    check("hold_data2", data, 8'h3C);
    check("hold_valid", valid, 1'b1);
    check("hold_vrise", n_vrise - v0, 1);
    check("hold_ovr", n_ovr - o0, 1);
    ready = 1'b1;
    @(posedge clk); #1;
    check("drain_valid", valid, 1'b0);
    @(negedge clk);

    // 0x55 with low stop bit, line held low (break)
    snap();
    send(8'h55, 1'b0);
    rx = 1'b0;
    repeat (5 * CPB) @(negedge clk);
    check("brk_busy", busy, 1'b1);
    check("brk_ferr", n_ferr - f0, 1);
    check("brk_vrise", n_vrise - v0, 0);
    rx = 1'b1;
    repeat (6) @(negedge clk);
    check("brk_idle", busy, 1'b0);
    send(8'h01, 1'b1);
    repeat (2) @(negedge clk);
    check("brk_next_data", cap_data, 8'h01);
    check("brk_next_vrise", n_vrise - v0, 1);

    // short low glitch rejected
    snap();
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("gl_busy", busy, 1'b0);
    check("gl_vrise", n_vrise - v0, 0);
    check("gl_ferr", n_ferr - f0, 0);
    check("gl_ovr", n_ovr - o0, 0);

    // reset mid-frame during bit 3 of 0xFF
    snap();
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB + CPB / 2) @(negedge clk);
    check("mid_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mr_busy", busy, 1'b0);
    check("mr_data", data, 8'h00);
    check("mr_valid", valid, 1'b0);
    check("mr_ferr", frame_err, 1'b0);
    check("mr_ovr", overrun, 1'b0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    send(8'h12, 1'b1);
    repeat (2) @(negedge clk);
    check("mr_vrise", n_vrise - v0, 1);
    check("mr_after_data", cap_data, 8'h12);
    check("mr_after_ferr", n_ferr - f0, 0);

`ifdef SNAKE_LINK_PARITY_EN
    // 0x07 has three ones: even parity bit must be 1
    snap();
    tx_bit(1'b0);
    for (int i = 0; i < 8; i++) tx_bit(i < 3);
    tx_bit(1'b0);
    tx_bit(1'b1);
    repeat (2) @(negedge clk);
    check("par_bad_perr", n_perr - p0, 1);
    check("par_bad_vrise", n_vrise - v0, 0);
    snap();
    tx_bit(1'b0);
    for (int i = 0; i < 8; i++) tx_bit(i < 3);
    tx_bit(1'b1);
    tx_bit(1'b1);
    repeat (2) @(negedge clk);
    check("par_ok_perr", n_perr - p0, 0);
    check("par_ok_vrise", n_vrise - v0, 1);
    check("par_ok_data", cap_data, 8'h07);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
